// File: rtl/xotr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xotr_sequencer_pkg
// Description : Shared constants for the XOTR opcode sequencer: state
//               encoding, phase-timer defaults and opcode width.
// Revision    : 1.0 - initial release
// ============================================================================
package xotr_sequencer_pkg;

    // Opcode byte width on the memory bus
    localparam int c_OPC_W = 8;

    // Phase-timer defaults
    localparam int c_XPT_W   = 5;
    localparam int c_XPT_MAX = 31;

    // Sequencer state encoding
    localparam logic [1:0] c_ST_RESET = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_EXEC  = 2'd2;

endpackage : xotr_sequencer_pkg
`default_nettype wire

// File: rtl/xotr_sequencer_xpt_counter.sv
`default_nettype none
// ============================================================================
// Module      : xpt_counter
// Description : Execution-phase timer. Synchronous clear, count enable,
//               saturation at XPT_MAX, registered complement output and a
//               sticky overflow flag that only reset clears.
// Revision    : 1.0 - initial release
// ============================================================================
module xpt_counter
    import xotr_sequencer_pkg::*;
#(
    parameter int XPT_W   = c_XPT_W,
    parameter int XPT_MAX = c_XPT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [XPT_W-1:0] o_count,
    output logic [XPT_W-1:0] o_count_n,
    output logic             o_overflow
);

    localparam logic [XPT_W-1:0] c_MAX = XPT_MAX[XPT_W-1:0];

    logic [XPT_W-1:0] r_count;
    logic [XPT_W-1:0] r_count_n;
    logic             r_ovf;
    logic [XPT_W-1:0] w_inc;

    assign w_inc = r_count + 1'b1;

    // Count/clear/saturate; the complement is loaded from the same next value
    // so it can never disagree with the count on any cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_count_n <= '1;
            r_ovf     <= 1'b0;
        end else if (i_clr) begin
            r_count   <= '0;
            r_count_n <= '1;
        end else if (i_en && (r_count != c_MAX)) begin
            r_count   <= w_inc;
            r_count_n <= ~w_inc;
            if (w_inc == c_MAX) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_count    = r_count;
    assign o_count_n  = r_count_n;
    assign o_overflow = r_ovf;

endmodule : xpt_counter
`default_nettype wire

// File: rtl/xotr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xotr_sequencer
// Description : Opcode fetch/execute sequencer with XOTR prefix tracking.
//               Latches opcodes in FETCH, runs the phase timer in EXEC and
//               steers the main or XOTR decoder enable from the XOTR flag.
// Revision    : 1.0 - initial release
// ============================================================================
module xotr_sequencer
    import xotr_sequencer_pkg::*;
#(
    parameter int XPT_W   = c_XPT_W,
    parameter int XPT_MAX = c_XPT_MAX
) (
    input  logic               CLK,
    input  logic               notReset,
    input  logic [c_OPC_W-1:0] Data,
    input  logic               Fetch_Valid,
    input  logic               Wait,
    input  logic               PR_Reset_XPT,
    input  logic               P2_Set_CM1,
    input  logic               P2_Set_XOTR,
    input  logic               P2_Reset_XOTR,
    input  logic               Pa_Ophd,
    output logic [XPT_W-1:0]   XPT,
    output logic [XPT_W-1:0]   notXPT,
    output logic [c_OPC_W-1:0] Source,
    output logic [c_OPC_W-1:0] notSource,
    output logic               Enable_Main,
    output logic               Enable_XOTR,
    output logic               CM1,
    output logic               XOTR,
    output logic               XPT_Overflow
);

    logic [1:0]         r_state;
    logic [c_OPC_W-1:0] r_source;
    logic [c_OPC_W-1:0] r_source_n;
    logic               r_xotr;
    logic               w_in_fetch;
    logic               w_in_exec;
    logic               w_accept;
    logic               w_xpt_clr;
    logic               w_xpt_en;
    logic               w_unused;

    assign w_in_fetch = (r_state == c_ST_FETCH);
    assign w_in_exec  = (r_state == c_ST_EXEC);
    assign w_accept   = w_in_fetch & Fetch_Valid;
    assign w_xpt_clr  = w_accept | (w_in_exec & PR_Reset_XPT);
    assign w_xpt_en   = w_in_exec & ~Wait;

    // Opcode-handled feedback carries no state here: Source only moves on an
    // accepted fetch.
    assign w_unused = Pa_Ophd;

    // State transitions: one cycle in RESET, wait for an opcode in FETCH,
    // leave EXEC only when the decoder ends the phase and requests M1.
    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            r_state <= c_ST_RESET;
        end else begin
            case (r_state)
                c_ST_RESET: r_state <= c_ST_FETCH;
                c_ST_FETCH: if (Fetch_Valid) r_state <= c_ST_EXEC;
                c_ST_EXEC:  if (PR_Reset_XPT && P2_Set_CM1) r_state <= c_ST_FETCH;
                default:    r_state <= c_ST_RESET;
            endcase
        end
    end

    // Opcode latch with its complement loaded alongside.
    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            r_source   <= '0;
            r_source_n <= '1;
        end else if (w_accept) begin
            r_source   <= Data;
            r_source_n <= ~Data;
        end
    end

    // XOTR flag: updated only in EXEC; set has priority over clear.
    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            r_xotr <= 1'b0;
        end else if (w_in_exec) begin
            if (P2_Set_XOTR) begin
                r_xotr <= 1'b1;
            end else if (P2_Reset_XOTR) begin
                r_xotr <= 1'b0;
            end
        end
    end

    xpt_counter #(
        .XPT_W   (XPT_W),
        .XPT_MAX (XPT_MAX)
    ) u_xpt_counter (
        .clk        (CLK),
        .rst_n      (notReset),
        .i_clr      (w_xpt_clr),
        .i_en       (w_xpt_en),
        .o_count    (XPT),
        .o_count_n  (notXPT),
        .o_overflow (XPT_Overflow)
    );

    assign Source      = r_source;
    assign notSource   = r_source_n;
    assign XOTR        = r_xotr;
    assign CM1         = w_in_fetch;
    assign Enable_Main = w_in_exec & ~r_xotr;
    assign Enable_XOTR = w_in_exec &  r_xotr;

endmodule : xotr_sequencer
`default_nettype wire

// File: doc/xotr_sequencer.md
XOTR_SEQUENCER -- requirements
Module: xotr_sequencer

Interface
REQ-001 Parameter XPT_W, default 5, width of execution-phase timer XPT.
REQ-002 Parameter XPT_MAX, default 31, saturation value of XPT.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 notReset  input  1  asynchronous, active-low reset.
REQ-005 Data  input  8  opcode byte from memory bus.
REQ-006 Fetch_Valid  input  1  Data holds a valid opcode this cycle.
REQ-007 Wait  input  1  stall; freezes XPT during EXEC.
REQ-008 PR_Reset_XPT  input  1  decoder feedback: clear XPT, end current opcode phase.
REQ-009 P2_Set_CM1  input  1  decoder feedback: next cycle starts an M1 fetch.
REQ-010 P2_Set_XOTR  input  1  decoder feedback: prefix seen, next opcode uses XOTR table.
REQ-011 P2_Reset_XOTR  input  1  decoder feedback: XOTR opcode complete.
REQ-012 Pa_Ophd  input  1  decoder feedback: opcode handled, Source may be released.
REQ-013 XPT / notXPT  output  XPT_W each  phase timer and its bitwise complement.
REQ-014 Source / notSource  output  8 each  latched opcode and its bitwise complement.
REQ-015 Enable_Main  output  1  enable for main-table decoder tree.
REQ-016 Enable_XOTR  output  1  enable for XOTR-table decoder tree.
REQ-017 CM1  output  1  M1 fetch request (high in FETCH).
REQ-018 XOTR  output  1  current XOTR flag.
REQ-019 XPT_Overflow  output  1  sticky: XPT reached XPT_MAX without PR_Reset_XPT.

Function
REQ-020 States SHALL be RESET, FETCH, EXEC; RESET->FETCH unconditionally after one cycle.
REQ-021 FETCH: CM1=1, enables low; on Fetch_Valid, Source<=Data, XPT<=0, next state EXEC.
REQ-022 FETCH without Fetch_Valid SHALL hold state and all registers indefinitely.
REQ-023 EXEC: Enable_XOTR=XOTR, Enable_Main=~XOTR, CM1=0; exactly one enable high.
REQ-024 EXEC: XPT increments by 1 per cycle when Wait=0 and PR_Reset_XPT=0; holds when Wait=1.
REQ-025 XPT SHALL saturate at XPT_MAX (no wrap) and set XPT_Overflow, cleared only by reset.
REQ-026 PR_Reset_XPT in EXEC SHALL clear XPT next cycle regardless of Wait.
REQ-027 PR_Reset_XPT with P2_Set_CM1 SHALL move to FETCH; PR_Reset_XPT alone stays EXEC with XPT=0.
REQ-028 P2_Set_CM1 without PR_Reset_XPT SHALL be ignored.
REQ-029 P2_Set_XOTR sets XOTR, P2_Reset_XOTR clears it; simultaneous assertion: set wins.
REQ-030 XOTR SHALL persist across FETCH, so the post-prefix opcode decodes via Enable_XOTR.
REQ-031 Pa_Ophd SHALL not alter Source; Source changes only at accepted fetch.
REQ-032 All feedback inputs SHALL be ignored outside EXEC.
REQ-033 notXPT and notSource SHALL be registered complements, never differing from ~XPT / ~Source on any cycle.
REQ-034 Decoder latency: feedback sampled at edge N affects XPT/state/XOTR at edge N, visible cycle N+1.

Reset
REQ-035 On notReset low: state RESET, XPT=0, notXPT=all ones, Source=00h, notSource=FFh, XOTR=0, XPT_Overflow=0, CM1=0, enables 0.
REQ-036 Reset mid-EXEC SHALL abort immediately; first fetch begins two edges after release.

Structure
REQ-037 Shared package holds state encoding, XPT_W, XPT_MAX, opcode width constant.
REQ-038 One sub-module xpt_counter: XPT_W-bit counter with sync clear, enable, saturation, complement output, overflow flag.

Verification
REQ-039 Reset release, Fetch_Valid with Data=80h -> EXEC, Source=80h, notSource=7Fh, Enable_Main=1, XPT 0,1,2.
REQ-040 EXEC, XPT=3, PR_Reset_XPT+P2_Set_CM1 -> next cycle FETCH, CM1=1, XPT=0, notXPT=1Fh.
REQ-041 Fetch EDh, P2_Set_XOTR+PR_Reset_XPT+P2_Set_CM1 at XPT=0, fetch 44h -> Enable_XOTR=1, Source=44h; P2_Reset_XOTR at end -> XOTR=0.
REQ-042 EXEC, Wait=1 for 4 cycles at XPT=2 -> XPT stays 2; PR_Reset_XPT with Wait=1 -> XPT=0.
REQ-043 EXEC, no feedback 40 cycles -> XPT stops at 31, XPT_Overflow=1 sticky until reset.
REQ-044 P2_Set_XOTR and P2_Reset_XOTR same cycle -> XOTR=1; notReset low at XPT=5 -> all reset values same cycle.
